seg_display_editor: RTL and testbench

// Six-digit 7-segment display editor: divides the 50 MHz clock into 1 ms/10 ms time bases, edits a 6-digit BCD value,

---
 rtl/seg_display_pkg.sv | 39 +++
 rtl/seg_tick_gen.sv | 52 +++++
 rtl/seg_display_editor.sv | 170 +++++++++++++++++
 tb/tb_seg_display_editor.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_display_pkg.sv
// Shared constants and the 7-segment encoder for the six-digit display editor.
package seg_display_pkg;

    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int KEY_ENTER = 4;

    localparam logic [2:0] POINT_NONE = 3'd7;
    localparam logic [2:0] DIGIT_LAST = 3'd5;

    typedef enum logic [2:0] {
        EV_NONE  = 3'd0,
        EV_UP    = 3'd1,
        EV_DOWN  = 3'd2,
        EV_LEFT  = 3'd3,
        EV_RIGHT = 3'd4,
        EV_ENTER = 3'd5
    } key_event_e;

    // Active-low {dp,g,f,e,d,c,b,a} pattern, dp off; non-BCD input blanks the digit.
    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Divides the system clock into a 1 ms clock-enable pulse and keeps the
// free-running millisecond and 10 ms time counters.
module seg_tick_gen #(
    parameter int MS_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ms_tick_o,
    output logic [31:0] time_ms_o,
    output logic [31:0] time_10ms_o
);

    localparam int DW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(MS_DIV - 1);

    logic [DW-1:0] div_q;
    logic [3:0]    dec_q;
    logic          ms_tick_q;
    logic [31:0]   time_ms_q;
    logic [31:0]   time_10ms_q;

    // Clock divider, decade prescaler and time counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            dec_q       <= 4'd0;
            ms_tick_q   <= 1'b0;
            time_ms_q   <= 32'd0;
            time_10ms_q <= 32'd0;
        end else begin
            ms_tick_q <= 1'b0;
            if (div_q == DIV_LAST) begin
                div_q     <= '0;
                ms_tick_q <= 1'b1;
                time_ms_q <= time_ms_q + 32'd1;
                if (dec_q == 4'd9) begin
                    dec_q       <= 4'd0;
                    time_10ms_q <= time_10ms_q + 32'd1;
                end else begin
                    dec_q <= dec_q + 4'd1;
                end
            end else begin
                div_q <= div_q + DW'(1);
            end
        end
    end

    assign ms_tick_o   = ms_tick_q;
    assign time_ms_o   = time_ms_q;
    assign time_10ms_o = time_10ms_q;

endmodule

// File: rtl/seg_display_editor.sv
// Six-digit BCD editor with cursor blink, decimal point, key-click beep and
// multiplexed active-low 7-segment drive.
module seg_display_editor
    import seg_display_pkg::*;
#(
    parameter int MS_DIV   = 50000,
    parameter int BLINK_MS = 250,
    parameter int BEEP_MS  = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  key_state,
    output logic [7:0]  DIG,
    output logic [5:0]  SEL,
    output logic        beep,
    output logic [31:0] system_time_ms,
    output logic [31:0] system_time_10ms,
    output logic [23:0] value_bcd,
    output logic [2:0]  cursor_pos,
    output logic [2:0]  point_pos
);

    localparam int BW = $clog2(BEEP_MS + 1);
    localparam int LW = $clog2(BLINK_MS + 1);
    localparam logic [BW-1:0] BEEP_LOAD  = BW'(BEEP_MS);
    localparam logic [LW-1:0] BLINK_LAST = LW'(BLINK_MS - 1);

    logic          ms_tick_s;
    key_event_e    ev_s;
    logic          ev_any_s;
    logic [3:0]    cur_digit_s;
    logic [3:0]    scan_digit_s;
    logic          unused_keys_s;

    logic [23:0]   value_q,     value_d;
    logic [2:0]    cursor_q,    cursor_d;
    logic [2:0]    point_q,     point_d;
    logic [BW-1:0] beep_cnt_q,  beep_cnt_d;
    logic          beep_q;
    logic [LW-1:0] blink_cnt_q, blink_cnt_d;
    logic          hidden_q,    hidden_d;
    logic [2:0]    scan_q,      scan_d;
    logic [7:0]    dig_q,       dig_d;
    logic [5:0]    sel_q,       sel_d;

    assign unused_keys_s = ^key_state[9:5];

    seg_tick_gen #(.MS_DIV(MS_DIV)) u_tick (
        .clk         (clk),
        .rst_n       (rst_n),
        .ms_tick_o   (ms_tick_s),
        .time_ms_o   (system_time_ms),
        .time_10ms_o (system_time_10ms)
    );

    // Pick the single highest-priority key pulse of this cycle.
    always_comb begin
        ev_s = EV_NONE;
        if (key_state[KEY_UP]) begin
            ev_s = EV_UP;
        end else if (key_state[KEY_DOWN]) begin
            ev_s = EV_DOWN;
        end else if (key_state[KEY_LEFT]) begin
            ev_s = EV_LEFT;
        end else if (key_state[KEY_RIGHT]) begin
            ev_s = EV_RIGHT;
        end else if (key_state[KEY_ENTER]) begin
            ev_s = EV_ENTER;
        end else begin
            ev_s = EV_NONE;
        end
    end

    assign ev_any_s    = (ev_s != EV_NONE);
    assign cur_digit_s = value_q[{cursor_q, 2'b00} +: 4];

    // Editing datapath: digits wrap individually, cursor wraps over six digits.
    always_comb begin
        value_d  = value_q;
        cursor_d = cursor_q;
        point_d  = point_q;
        case (ev_s)
            EV_UP:    value_d[{cursor_q, 2'b00} +: 4] = (cur_digit_s == 4'd9) ? 4'd0 : cur_digit_s + 4'd1;
            EV_DOWN:  value_d[{cursor_q, 2'b00} +: 4] = (cur_digit_s == 4'd0) ? 4'd9 : cur_digit_s - 4'd1;
            EV_LEFT:  cursor_d = (cursor_q == DIGIT_LAST) ? 3'd0 : cursor_q + 3'd1;
            EV_RIGHT: cursor_d = (cursor_q == 3'd0) ? DIGIT_LAST : cursor_q - 3'd1;
            EV_ENTER: point_d  = (point_q == cursor_q) ? POINT_NONE : cursor_q;
            default:  value_d  = value_q;
        endcase
    end

    // Beep and blink timers; any accepted key restarts both.
    always_comb begin
        beep_cnt_d  = beep_cnt_q;
        blink_cnt_d = blink_cnt_q;
        hidden_d    = hidden_q;
        if (ev_any_s) begin
            beep_cnt_d  = BEEP_LOAD;
            blink_cnt_d = '0;
            hidden_d    = 1'b0;
        end else if (ms_tick_s) begin
            beep_cnt_d = (beep_cnt_q != '0) ? beep_cnt_q - BW'(1) : beep_cnt_q;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                hidden_d    = ~hidden_q;
            end else begin
                blink_cnt_d = blink_cnt_q + LW'(1);
            end
        end else begin
            beep_cnt_d = beep_cnt_q;
        end
    end

    // Scan mux, built from next-state so DIG/SEL land on the same edge as the state.
    always_comb begin
        scan_d = scan_q;
        if (ms_tick_s) begin
            scan_d = (scan_q == DIGIT_LAST) ? 3'd0 : scan_q + 3'd1;
        end else begin
            scan_d = scan_q;
        end
        sel_d        = ~(6'b000001 << scan_d);
        scan_digit_s = value_d[{scan_d, 2'b00} +: 4];
        if ((scan_d == cursor_d) && hidden_d) begin
            dig_d = 8'hFF;
        end else begin
            dig_d = seg_code(scan_digit_s);
        end
        if (scan_d == point_d) begin
            dig_d[7] = 1'b0;
        end else begin
            dig_d[7] = dig_d[7];
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q     <= 24'd0;
            cursor_q    <= 3'd0;
            point_q     <= POINT_NONE;
            beep_cnt_q  <= '0;
            beep_q      <= 1'b0;
            blink_cnt_q <= '0;
            hidden_q    <= 1'b0;
            scan_q      <= 3'd0;
            dig_q       <= 8'hC0;
            sel_q       <= 6'b111110;
        end else begin
            value_q     <= value_d;
            cursor_q    <= cursor_d;
            point_q     <= point_d;
            beep_cnt_q  <= beep_cnt_d;
            beep_q      <= (beep_cnt_d != '0);
            blink_cnt_q <= blink_cnt_d;
            hidden_q    <= hidden_d;
            scan_q      <= scan_d;
            dig_q       <= dig_d;
            sel_q       <= sel_d;
        end
    end

    assign DIG        = dig_q;
    assign SEL        = sel_q;
    assign beep       = beep_q;
    assign value_bcd  = value_q;
    assign cursor_pos = cursor_q;
    assign point_pos  = point_q;

endmodule

// File: tb/tb_seg_display_editor.sv
// Randomised scoreboard bench for seg_display_editor against a millisecond-level model.
module tb_seg_display_editor;

    localparam int MS_DIV   = 4;
    localparam int BLINK_MS = 3;
    localparam int BEEP_MS  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  key_state = 10'd0;
    logic [7:0]  DIG;
    logic [5:0]  SEL;
    logic        beep;
    logic [31:0] system_time_ms;
    logic [31:0] system_time_10ms;
    logic [23:0] value_bcd;
    logic [2:0]  cursor_pos;
    logic [2:0]  point_pos;

    seg_display_editor #(.MS_DIV(MS_DIV), .BLINK_MS(BLINK_MS), .BEEP_MS(BEEP_MS)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .key_state        (key_state),
        .DIG              (DIG),
        .SEL              (SEL),
        .beep             (beep),
        .system_time_ms   (system_time_ms),
        .system_time_10ms (system_time_10ms),
        .value_bcd        (value_bcd),
        .cursor_pos       (cursor_pos),
        .point_pos        (point_pos)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] value;
        logic [2:0]  cur;
        logic [2:0]  pt;
        logic        bp;
        logic [31:0] tms;
        logic [31:0] t10;
        logic [5:0]  sel;
        logic [7:0]  dig;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    logic [7:0] codes [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    // Reference model: whole-millisecond view of the editor.
    int n;
    int digits [6];
    int cursor;
    int point;
    bit ev_seen;
    int ev_ms;
    int blink_ref;

    function automatic int ms_seen(input int c);
        return (c >= 1) ? (c - 1) / MS_DIV : 0;
    endfunction

    function automatic void model_reset();
        n = 0;
        for (int i = 0; i < 6; i++) digits[i] = 0;
        cursor    = 0;
        point     = 7;
        ev_seen   = 1'b0;
        ev_ms     = 0;
        blink_ref = 0;
    endfunction

    function automatic exp_t model_expect();
        exp_t e;
        int ms, idx;
        bit hidden;
        ms = ms_seen(n);
        for (int i = 0; i < 6; i++) e.value[i*4 +: 4] = 4'(digits[i]);
        e.cur  = 3'(cursor);
        e.pt   = 3'(point);
        e.bp   = ev_seen && ((ms - ev_ms) < BEEP_MS);
        e.tms  = 32'(n / MS_DIV);
        e.t10  = 32'(n / (MS_DIV * 10));
        idx    = ms % 6;
        hidden = (((ms - blink_ref) / BLINK_MS) % 2) == 1;
        e.sel  = ~(6'b000001 << idx);
        e.dig  = (idx == cursor && hidden) ? 8'hFF : codes[digits[idx]];
        if (idx == point) e.dig[7] = 1'b0;
        return e;
    endfunction

    task automatic step(input logic [9:0] k);
        int evt;
        @(negedge clk);
        key_state = k;
        @(posedge clk);
        #1;
        key_state = 10'd0;
        n++;
        evt = -1;
        for (int i = 0; i < 5; i++) begin
            if (k[i]) begin
                evt = i;
                break;
            end
        end
        case (evt)
            0: digits[cursor] = (digits[cursor] + 1) % 10;
            1: digits[cursor] = (digits[cursor] + 9) % 10;
            2: cursor = (cursor + 1) % 6;
            3: cursor = (cursor + 5) % 6;
            4: point = (point == cursor) ? 7 : cursor;
            default: ;
        endcase
        if (evt >= 0) begin
            ev_seen   = 1'b1;
            ev_ms     = ms_seen(n);
            blink_ref = ms_seen(n);
        end
        exp_q.push_back(model_expect());
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(10'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        key_state = 10'd0;
        model_reset();
        exp_q.push_back(model_expect());
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: compare every queued expectation against the DUT away from the clock edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("value_bcd",  32'(value_bcd),  32'(e.value));
                check("cursor_pos", 32'(cursor_pos), 32'(e.cur));
                check("point_pos",  32'(point_pos),  32'(e.pt));
                check("beep",       32'(beep),       32'(e.bp));
                check("time_ms",    system_time_ms,  e.tms);
                check("time_10ms",  system_time_10ms, e.t10);
                check("SEL",        32'(SEL),        32'(e.sel));
                check("DIG",        32'(DIG),        32'(e.dig));
            end
        end
    end

    localparam logic [9:0] K_UP    = 10'b00000_00001;
    localparam logic [9:0] K_DOWN  = 10'b00000_00010;
    localparam logic [9:0] K_LEFT  = 10'b00000_00100;
    localparam logic [9:0] K_RIGHT = 10'b00000_01000;
    localparam logic [9:0] K_ENTER = 10'b00000_10000;

    initial begin
        logic [9:0] k;
        model_reset();
        do_reset();
        idle(40);
        repeat (3) step(K_UP);
        repeat (4) step(K_DOWN);
        idle(5);
        step(K_UP);
        step(K_RIGHT);
        step(K_LEFT);
        step(K_LEFT);
        step(K_UP);
        idle(3);
        step(K_LEFT);
        step(K_ENTER);
        idle(30);
        step(K_ENTER);
        idle(3);
        step(K_UP | K_LEFT);
        idle(10);
        step(K_DOWN);
        idle(4);
        step(K_DOWN);
        idle(40);
        step(K_UP);
        idle(3);
        do_reset();
        idle(6);
        for (int i = 0; i < 700; i++) begin
            k = {5'($urandom), 5'd0};
            if ($urandom_range(0, 5) == 0) k[4:0] = 5'($urandom);
            step(k);
            if (i == 350) do_reset();
        end
        idle(2);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
